// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_hazard_ctrl_pkg: select encodings, FSM states and shadow-stage field widths
package fwd_hazard_ctrl_pkg;
  localparam int SEL_W = 5;
  localparam int VLD_W = 2;
  localparam int WR_W = 2;
  localparam logic [SEL_W-1:0] SEL_IDEX    = 5'b00001;
  localparam logic [SEL_W-1:0] SEL_EXM_TOP = 5'b00010;
  localparam logic [SEL_W-1:0] SEL_EXM_BOT = 5'b00100;
  localparam logic [SEL_W-1:0] SEL_MWB_TOP = 5'b01000;
  localparam logic [SEL_W-1:0] SEL_MWB_BOT = 5'b10000;
  typedef enum logic {RUN = 1'b0, LSTALL = 1'b1} state_e;
endpackage

// File: rtl/fwd_hazard_ctrl_select.sv
// fwd_hazard_ctrl_select: one-hot forwarding priority selector for one ALU operand
module fwd_hazard_ctrl_select import fwd_hazard_ctrl_pkg::*; #(
  parameter int W = 5
) (
  input  logic [W-1:0]     src_i,
  input  logic             vld_i,
  input  logic [W-1:0]     exm_dst_top_i,
  input  logic [W-1:0]     exm_dst_bot_i,
  input  logic [WR_W-1:0]  exm_wr_i,
  input  logic             exm_is_load_i,
  input  logic [W-1:0]     mwb_dst_top_i,
  input  logic [W-1:0]     mwb_dst_bot_i,
  input  logic [WR_W-1:0]  mwb_wr_i,
  output logic [SEL_W-1:0] sel_o
);
  logic exm_bot_hit, exm_top_hit, mwb_bot_hit, mwb_top_hit;
  // youngest producer wins; a load in MEM has nothing to forward yet
  always_comb begin
    exm_bot_hit = !exm_is_load_i && exm_wr_i[1] && exm_dst_bot_i == src_i;
    exm_top_hit = !exm_is_load_i && exm_wr_i[0] && exm_dst_top_i == src_i;
    mwb_bot_hit = mwb_wr_i[1] && mwb_dst_bot_i == src_i;
    mwb_top_hit = mwb_wr_i[0] && mwb_dst_top_i == src_i;
    sel_o = !vld_i      ? SEL_IDEX    :
            exm_bot_hit ? SEL_EXM_BOT :
            exm_top_hit ? SEL_EXM_TOP :
            mwb_bot_hit ? SEL_MWB_BOT :
            mwb_top_hit ? SEL_MWB_TOP : SEL_IDEX;
  end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage forwarding selects and load-use stall; FWD_STATS_EN adds stall/forward counters
module fwd_hazard_ctrl import fwd_hazard_ctrl_pkg::*; #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic [REG_ADDR_W-1:0] id_src_top_i,
  input  logic [REG_ADDR_W-1:0] id_src_bot_i,
  input  logic                  id_src_top_vld_i,
  input  logic                  id_src_bot_vld_i,
  input  logic [REG_ADDR_W-1:0] id_dst_top_i,
  input  logic [REG_ADDR_W-1:0] id_dst_bot_i,
  input  logic                  id_wr_top_i,
  input  logic                  id_wr_bot_i,
  input  logic                  id_is_load_i,
  input  logic                  id_ex_flush_i,
  input  logic                  mem_busy_i,
  output logic [SEL_W-1:0]      alu_input_sel_top_o,
  output logic [SEL_W-1:0]      alu_input_sel_bot_o,
  output logic                  stall_if_id_o
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_count_o,
  output logic [CNT_W-1:0]      fwd_count_o
`endif
);
  typedef struct packed {
    logic [REG_ADDR_W-1:0] src_top;
    logic [REG_ADDR_W-1:0] src_bot;
    logic [VLD_W-1:0]      src_vld;
    logic [REG_ADDR_W-1:0] dst_top;
    logic [REG_ADDR_W-1:0] dst_bot;
    logic [WR_W-1:0]       wr;
    logic                  is_load;
  } stage_t;

  function automatic logic slot_hit(input logic [REG_ADDR_W-1:0] src, input logic vld,
                                    input logic [REG_ADDR_W-1:0] d_top, input logic [REG_ADDR_W-1:0] d_bot,
                                    input logic [WR_W-1:0] wr);
    return vld && ((wr[0] && d_top == src) || (wr[1] && d_bot == src));
  endfunction

  stage_t id_stage, ex_d, ex_q, mem_q, wb_q;
  state_e state_q, state_d;
  logic   load_use;

  assign id_stage = '{src_top: id_src_top_i, src_bot: id_src_bot_i,
                      src_vld: {id_src_bot_vld_i, id_src_top_vld_i},
                      dst_top: id_dst_top_i, dst_bot: id_dst_bot_i,
                      wr: {id_wr_bot_i, id_wr_top_i}, is_load: id_is_load_i};
  assign load_use = ex_q.is_load &&
                    (slot_hit(id_src_top_i, id_src_top_vld_i, ex_q.dst_top, ex_q.dst_bot, ex_q.wr) ||
                     slot_hit(id_src_bot_i, id_src_bot_vld_i, ex_q.dst_top, ex_q.dst_bot, ex_q.wr));
  assign ex_d = (stall_if_id_o || id_ex_flush_i) ? '0 : id_stage;

  // shadow pipeline advances unless memory freezes everything
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_busy_i) begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end

  // load-use FSM state register
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) state_q <= RUN;
    else            state_q <= state_d;

  // RUN enters LSTALL on a detected stall; LSTALL leaves on the next advancing cycle
  always_comb
    state_d = (state_q == RUN) ? (stall_if_id_o ? LSTALL : RUN) : (mem_busy_i ? LSTALL : RUN);

  // stall only in RUN, and never while frozen or flushing
  always_comb
    stall_if_id_o = (state_q == RUN) && !mem_busy_i && !id_ex_flush_i && load_use;

  fwd_hazard_ctrl_select #(.W(REG_ADDR_W)) u_sel_top (
    .src_i(ex_q.src_top), .vld_i(ex_q.src_vld[0]),
    .exm_dst_top_i(mem_q.dst_top), .exm_dst_bot_i(mem_q.dst_bot), .exm_wr_i(mem_q.wr),
    .exm_is_load_i(mem_q.is_load),
    .mwb_dst_top_i(wb_q.dst_top), .mwb_dst_bot_i(wb_q.dst_bot), .mwb_wr_i(wb_q.wr),
    .sel_o(alu_input_sel_top_o)
  );

  fwd_hazard_ctrl_select #(.W(REG_ADDR_W)) u_sel_bot (
    .src_i(ex_q.src_bot), .vld_i(ex_q.src_vld[1]),
    .exm_dst_top_i(mem_q.dst_top), .exm_dst_bot_i(mem_q.dst_bot), .exm_wr_i(mem_q.wr),
    .exm_is_load_i(mem_q.is_load),
    .mwb_dst_top_i(wb_q.dst_top), .mwb_dst_bot_i(wb_q.dst_bot), .mwb_wr_i(wb_q.wr),
    .sel_o(alu_input_sel_bot_o)
  );

  logic unused_wb;
  assign unused_wb = ^{wb_q.src_top, wb_q.src_bot, wb_q.src_vld, wb_q.is_load};

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;
  logic fwd_any;
  assign fwd_any = (alu_input_sel_top_o != SEL_IDEX) || (alu_input_sel_bot_o != SEL_IDEX);
  // saturating stall and forwarding event counters
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_if_id_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (!mem_busy_i && fwd_any && !(&fwd_cnt_q)) fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
    end
  assign stall_count_o = stall_cnt_q;
  assign fwd_count_o   = fwd_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed checks of forwarding selects and load-use stall
module tb_fwd_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] st, sb, dt, db;
  logic stv, sbv, wt, wb, ld, flush, busy;
  logic [4:0] sel_t, sel_b;
  logic stall;
`ifdef FWD_STATS_EN
  logic [15:0] sc, fc;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .id_src_top_i(st), .id_src_bot_i(sb), .id_src_top_vld_i(stv), .id_src_bot_vld_i(sbv),
    .id_dst_top_i(dt), .id_dst_bot_i(db), .id_wr_top_i(wt), .id_wr_bot_i(wb),
    .id_is_load_i(ld), .id_ex_flush_i(flush), .mem_busy_i(busy),
    .alu_input_sel_top_o(sel_t), .alu_input_sel_bot_o(sel_b), .stall_if_id_o(stall)
`ifdef FWD_STATS_EN
    , .stall_count_o(sc), .fwd_count_o(fc)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic [4:0] a, input logic av, input logic [4:0] b, input logic bv,
                    input logic [4:0] c, input logic cw, input logic [4:0] d, input logic dw,
                    input logic l);
    st = a; stv = av; sb = b; sbv = bv; dt = c; wt = cw; db = d; wb = dw; ld = l;
    #1;
  endtask

  task automatic idle;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain;
    idle();
    repeat (3) tick();
  endtask

  initial begin
    flush = 0;
    busy = 0;
    idle();
    chk("rst_sel_top", sel_t, 5'b00001);
    chk("rst_sel_bot", sel_b, 5'b00001);
    chk("rst_stall", stall, 0);
    tick();
    rst_n = 1;
    tick();
    // back-to-back ALU dependency through EX/MEM top
    id(0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    id(3, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_stall", stall, 0);
    tick();
    idle();
    chk("t1_sel_top", sel_t, 5'b00010);
    chk("t1_sel_bot", sel_b, 5'b00001);
    drain();
    // two-deep dependency through MEM/WB bot
    id(0, 0, 0, 0, 0, 0, 5, 1, 0); tick();
    id(1, 1, 0, 0, 9, 1, 0, 0, 0); tick();
    id(0, 0, 5, 1, 0, 0, 0, 0, 0); tick();
    idle();
    chk("t2_sel_bot", sel_b, 5'b10000);
    chk("t2_sel_top", sel_t, 5'b00001);
    drain();
    // load-use: one stall cycle then forward from MEM/WB top
    id(0, 0, 0, 0, 2, 1, 0, 0, 1); tick();
    id(2, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_stall", stall, 1);
    tick();
    chk("t3_lstall", stall, 0);
    chk("t3_bubble_sel", sel_t, 5'b00001);
    tick();
    chk("t3_sel_top", sel_t, 5'b01000);
    chk("t3_stall_after", stall, 0);
    drain();
    // EX/MEM top beats MEM/WB bot
    id(0, 0, 0, 0, 0, 0, 7, 1, 0); tick();
    id(0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
    id(7, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    idle();
    chk("t4_prio", sel_t, 5'b00010);
    drain();
    // dual write in one stage: bot wins
    id(0, 0, 0, 0, 7, 1, 7, 1, 0); tick();
    id(7, 1, 7, 1, 0, 0, 0, 0, 0); tick();
    idle();
    chk("t4_dual_bot", sel_b, 5'b00100);
    chk("t4_dual_top", sel_t, 5'b00100);
    drain();
    // flush overrides load-use and inserts a bubble
    id(0, 0, 0, 0, 2, 1, 0, 0, 1); tick();
    flush = 1;
    id(2, 1, 0, 0, 11, 1, 0, 0, 0);
    chk("t5_stall", stall, 0);
    tick();
    flush = 0;
    id(11, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_sel_top", sel_t, 5'b00001);
    chk("t5_sel_bot", sel_b, 5'b00001);
    chk("t5_stall2", stall, 0);
    tick();
    idle();
    chk("t5_no_fwd", sel_t, 5'b00001);
    drain();
    // freeze for 3 cycles with a pending load-use hazard
    id(0, 0, 0, 0, 6, 1, 0, 0, 0); tick();
    id(6, 1, 0, 0, 12, 1, 0, 0, 1); tick();
    id(12, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_fwd", sel_t, 5'b00010);
    busy = 1;
    #1;
    repeat (3) begin
      chk("t6_busy_sel", sel_t, 5'b00010);
      chk("t6_busy_stall", stall, 0);
      tick();
    end
    busy = 0;
    #1;
    chk("t6_stall", stall, 1);
    tick();
    chk("t6_lstall", stall, 0);
    tick();
    chk("t6_sel_top", sel_t, 5'b01000);
    drain();
    // asynchronous reset mid-dependency
    id(0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    id(3, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("t7_pre", sel_t, 5'b00010);
    rst_n = 0;
    #1;
    chk("t7_rst_top", sel_t, 5'b00001);
    chk("t7_rst_bot", sel_b, 5'b00001);
    chk("t7_rst_stall", stall, 0);
`ifdef FWD_STATS_EN
    chk("t7_rst_sc", sc, 0);
    chk("t7_rst_fc", fc, 0);
`endif
    #2;
    rst_n = 1;
    idle();
    tick();
`ifdef FWD_STATS_EN
    id(0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    id(3, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    id(0, 0, 0, 0, 2, 1, 0, 0, 1); tick();
    id(2, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t8_stall", stall, 1);
    tick();
    chk("t8_sc", sc, 1);
    chk("t8_fc", fc, 1);
    drain();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
